writeback_commit: RTL

WRITEBACK_COMMIT -- requirements
Module: writeback_commit

---
 rtl/writeback_commit_pkg.sv | 61 ++++++
 rtl/writeback_commit_fifo.sv | 61 ++++++
 rtl/writeback_commit.sv | 97 +++++++++
 3 files changed

// File: rtl/writeback_commit_pkg.sv
// Shared types for the writeback/commit stage: memory-stage bundles, register-file
// write bundles, exception classes and the commit-trace entry.
package writeback_commit_pkg;

   typedef logic [4:0] creg_addr_t;

   typedef enum logic [2:0] {
      NORMAL    = 3'd0,
      BRANCH    = 3'd1,
      EXCEPTION = 3'd2,
      ERET      = 3'd3
   } ctype_t;

   typedef struct packed {
      logic regwrite;
      logic memtoreg;
      logic hitoreg;
      logic lotoreg;
      logic cp0toreg;
   } control_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      ctype_t      ctype;
      control_t    ctl;
      creg_addr_t  wa;
      logic [31:0] alu_out;
      logic [31:0] rd;
   } memory_data_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      creg_addr_t  wa;
      logic [31:0] wd;
      control_t    ctl;
   } writeback_data_t;

   typedef struct packed {
      logic [31:0] pc;
      creg_addr_t  wa;
      logic [31:0] wd;
   } trace_entry_t;

   function automatic logic isTrap(input ctype_t c);
      return (c == EXCEPTION) || (c == ERET);
   endfunction

   // HI/LO/CP0 moves outrank a load, which outranks the ALU result.
   function automatic logic [31:0] selectWd(input memory_data_t m, input logic [31:0] hi,
                                            input logic [31:0] lo, input logic [31:0] cp0);
      if (m.ctl.hitoreg)       return hi;
      else if (m.ctl.lotoreg)  return lo;
      else if (m.ctl.cp0toreg) return cp0;
      else if (m.ctl.memtoreg) return m.rd;
      else if (m.ctl.regwrite) return m.alu_out;
      else                     return 32'd0;
   endfunction

endpackage

// File: rtl/writeback_commit_fifo.sv
// Commit-trace FIFO: up to LANES pushes per cycle packed in lane order, one pop per cycle.
module commit_trace_fifo
   import writeback_commit_pkg::*;
#(
   parameter int LANES = 2,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [LANES-1:0]       pushValid,
   input  trace_entry_t           pushData [LANES],
   input  logic                   popReady,
   output logic                   popValid,
   output trace_entry_t           popData,
   output logic [$clog2(DEPTH):0] count,
   output logic                   canAccept
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   trace_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] slot [LANES];
   logic [CNT_W-1:0] pushCount;
   logic             popFire;

   assign popValid  = (count != '0);
   assign popData   = mem[rdPtr];
   assign popFire   = popValid & popReady;
   assign canAccept = (count <= CNT_W'(DEPTH - LANES));

   // Skipped lanes leave no hole: each pushing lane lands after the ones below it.
   always_comb begin
      pushCount = '0;
      for (int i = 0; i < LANES; i++) begin
         slot[i] = wrPtr + PTR_W'(pushCount);
         if (pushValid[i]) pushCount = pushCount + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (pushValid[i]) mem[slot[i]] <= pushData[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         wrPtr <= wrPtr + PTR_W'(pushCount);
         rdPtr <= rdPtr + PTR_W'(popFire);
         count <= count + pushCount - CNT_W'(popFire);
      end
   end

endmodule

// File: rtl/writeback_commit.sv
// Writeback/commit stage: resolves per-lane register writes for a multi-issue group,
// registers them for the register file and logs committed writes to a trace FIFO.
module writeback_commit
   import writeback_commit_pkg::*;
#(
   parameter int LANES       = 2,
   parameter int TRACE_DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  memory_data_t                 dataM [LANES],
   input  logic                         m_valid,
   output logic                         m_ready,
   input  logic [31:0]                  hi_rd,
   input  logic [31:0]                  lo_rd,
   input  logic [31:0]                  cp0_rd,
   input  logic                         flush,
   output writeback_data_t              dataW [LANES],
   output logic                         trace_valid,
   input  logic                         trace_ready,
   output logic [31:0]                  trace_pc,
   output logic [31:0]                  trace_wd,
   output creg_addr_t                   trace_wa,
   output logic [$clog2(TRACE_DEPTH):0] trace_count
);

   logic             accept;
   logic             trapSeen;
   logic [LANES-1:0] baseEn;
   logic [LANES-1:0] finalEn;
   logic [LANES-1:0] pushValid;
   logic [31:0]      laneWd [LANES];
   trace_entry_t     pushData [LANES];
   trace_entry_t     popData;

   assign accept = m_valid & m_ready & ~flush;

   // A trap squashes itself and every younger lane; among surviving writers to the
   // same register only the youngest lane keeps its enable.
   always_comb begin
      trapSeen = 1'b0;
      baseEn   = '0;
      finalEn  = '0;
      for (int i = 0; i < LANES; i++) begin
         laneWd[i] = selectWd(dataM[i], hi_rd, lo_rd, cp0_rd);
         if (dataM[i].valid && isTrap(dataM[i].ctype)) trapSeen = 1'b1;
         baseEn[i] = dataM[i].valid && dataM[i].ctl.regwrite && !trapSeen && (dataM[i].wa != '0);
      end
      for (int i = 0; i < LANES; i++) begin
         finalEn[i] = baseEn[i];
         for (int j = i + 1; j < LANES; j++) begin
            if (baseEn[j] && (dataM[j].wa == dataM[i].wa)) finalEn[i] = 1'b0;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         pushValid[i] = accept & finalEn[i];
         pushData[i]  = '{pc: dataM[i].pc, wa: dataM[i].wa, wd: laneWd[i]};
      end
   end

   // Payload is held between groups; only the valid bits drop when nothing is accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LANES; i++) dataW[i] <= '0;
      end else if (accept) begin
         for (int i = 0; i < LANES; i++) begin
            dataW[i] <= '{valid: finalEn[i], pc: dataM[i].pc, wa: dataM[i].wa,
                          wd: laneWd[i], ctl: dataM[i].ctl};
         end
      end else begin
         for (int i = 0; i < LANES; i++) dataW[i].valid <= 1'b0;
      end
   end

   commit_trace_fifo #(
      .LANES (LANES),
      .DEPTH (TRACE_DEPTH)
   ) traceFifo (
      .clk       (clk),
      .reset     (reset),
      .pushValid (pushValid),
      .pushData  (pushData),
      .popReady  (trace_ready),
      .popValid  (trace_valid),
      .popData   (popData),
      .count     (trace_count),
      .canAccept (m_ready)
   );

   assign trace_pc = popData.pc;
   assign trace_wa = popData.wa;
   assign trace_wd = popData.wd;

endmodule
